// File: rtl/bus_mem_responder_pkg.sv
//----------------------------------------------------------------------------
// Module  : bus_mem_responder_pkg
// Brief   : Shared burst encodings, FSM states and beat-count helper for the
//           bus initiator and responder.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package bus_mem_responder_pkg;

  typedef enum logic [1:0] {
    BURST_NORMAL = 2'b00,
    BURST_INCR   = 2'b01,
    BURST_WRAP   = 2'b10,
    BURST_RSVD   = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    BEAT = 2'd2
  } state_e;

  localparam int unsigned BEAT_CNT_W = 5;
  localparam int unsigned WAIT_CNT_W = 3;

  // Reserved bursts behave as single-beat transfers.
  function automatic logic [BEAT_CNT_W-1:0] beat_count(input burst_e b,
                                                       input int unsigned burst_len);
    logic [BEAT_CNT_W-1:0] n;
    n = 5'd1;
    if (b == BURST_INCR || b == BURST_WRAP) n = BEAT_CNT_W'(burst_len);
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_sram_array.sv
//----------------------------------------------------------------------------
// Module  : bus_sram_array
// Brief   : DEPTH x 32 storage, one synchronous read port and one byte-enabled
//           write port.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module bus_sram_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] rd_addr_i,
  output logic [31:0]   rd_data_o,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [31:0]   wr_data_i,
  input  logic [3:0]    wr_be_i
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_data_q;

  always_ff @(posedge clk) begin
    rd_data_q <= mem_q[rd_addr_i];
    for (int i = 0; i < 4; i++) begin
      if (wr_be_i[i]) mem_q[wr_addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/bus_mem_responder.sv
//----------------------------------------------------------------------------
// Module  : bus_mem_responder
// Brief   : Wait-state bus memory slave supporting Normal, INCR and WRAP bursts.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module bus_mem_responder
  import bus_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned BURST_LEN   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ADDR,
  input  logic [1:0]  BURST,
  input  logic        REQ,
  input  logic        WRB,
  input  logic [31:0] WDATA,
  input  logic [3:0]  BSTROBE,
  output logic [31:0] RDATA,
  output logic        ACK,
  output logic        STALL
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] WRAP_MASK = AW'(BURST_LEN - 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
    WAIT_CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  state_e                state_q;
  logic                  ack_q;
  logic                  stall_q;
  logic                  wrb_q;
  burst_e                burst_q;
  logic [AW-1:0]         addr_q;
  logic [BEAT_CNT_W-1:0] beats_q;
  logic [WAIT_CNT_W-1:0] wait_q;

  logic [AW-1:0] start_idx;
  logic [AW-1:0] next_addr_d;
  logic [AW-1:0] rd_addr_d;
  logic [3:0]    wr_be_d;
  logic [31:0]   sram_rdata;
  logic          unused_addr;

  assign start_idx   = ADDR[AW+1:2];
  assign unused_addr = ^ADDR;

  always_comb begin
    next_addr_d = addr_q + 1'b1;
    if (burst_q == BURST_WRAP)
      next_addr_d = (addr_q & ~WRAP_MASK) | ((addr_q + 1'b1) & WRAP_MASK);
  end

  // Read address always points at the beat whose ACK may come next cycle.
  always_comb begin
    rd_addr_d = addr_q;
    case (state_q)
      IDLE:    rd_addr_d = start_idx;
      WAIT:    rd_addr_d = addr_q;
      BEAT:    rd_addr_d = next_addr_d;
      default: rd_addr_d = addr_q;
    endcase
  end

  assign wr_be_d = (state_q == BEAT && wrb_q && !rst) ? BSTROBE : 4'b0000;

  bus_sram_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk       (clk),
    .rd_addr_i (rd_addr_d),
    .rd_data_o (sram_rdata),
    .wr_addr_i (addr_q),
    .wr_data_i (WDATA),
    .wr_be_i   (wr_be_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      stall_q <= 1'b0;
      wrb_q   <= 1'b0;
      burst_q <= BURST_NORMAL;
      addr_q  <= '0;
      beats_q <= '0;
      wait_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (REQ) begin
            addr_q  <= start_idx;
            burst_q <= burst_e'(BURST);
            wrb_q   <= WRB;
            beats_q <= beat_count(burst_e'(BURST), BURST_LEN);
            stall_q <= 1'b1;
            if (WAIT_CYCLES > 0) begin
              state_q <= WAIT;
              wait_q  <= WAIT_INIT;
            end else begin
              state_q <= BEAT;
              ack_q   <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (wait_q == '0) begin
            state_q <= BEAT;
            ack_q   <= 1'b1;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        BEAT: begin
          ack_q <= 1'b0;
          if (beats_q == BEAT_CNT_W'(1)) begin
            state_q <= IDLE;
            stall_q <= 1'b0;
            beats_q <= '0;
          end else begin
            beats_q <= beats_q - 1'b1;
            addr_q  <= next_addr_d;
            if (WAIT_CYCLES > 0) begin
              state_q <= WAIT;
              wait_q  <= WAIT_INIT;
            end else begin
              ack_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign ACK   = ack_q;
  assign STALL = stall_q;
  assign RDATA = (ack_q && !wrb_q) ? sram_rdata : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_bus_mem_responder.sv
//----------------------------------------------------------------------------
// Module  : tb_bus_mem_responder
// Brief   : Self-checking bench; one responder with one wait state, one with none.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_bus_mem_responder;

  localparam int DEPTH = 64;
  localparam int BL    = 4;
  localparam int W0    = 1;
  localparam int W1    = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr   [2];
  logic [1:0]  burst  [2];
  logic        req    [2];
  logic        wrb    [2];
  logic [31:0] wdata  [2];
  logic [3:0]  strobe [2];
  logic [31:0] rdata  [2];
  logic        ack    [2];
  logic        stall  [2];

  int tests = 0;
  int fails = 0;

  logic [31:0] mdl [2][DEPTH];
  logic [31:0] wd_q [$];
  logic [3:0]  st_q [$];
  logic [31:0] rd_q [$];

  always #5 clk = ~clk;

  bus_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W0), .BURST_LEN(BL)) u_dut0 (
    .clk(clk), .rst(rst), .ADDR(addr[0]), .BURST(burst[0]), .REQ(req[0]),
    .WRB(wrb[0]), .WDATA(wdata[0]), .BSTROBE(strobe[0]), .RDATA(rdata[0]),
    .ACK(ack[0]), .STALL(stall[0])
  );

  bus_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W1), .BURST_LEN(BL)) u_dut1 (
    .clk(clk), .rst(rst), .ADDR(addr[1]), .BURST(burst[1]), .REQ(req[1]),
    .WRB(wrb[1]), .WDATA(wdata[1]), .BSTROBE(strobe[1]), .RDATA(rdata[1]),
    .ACK(ack[1]), .STALL(stall[1])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Word index of beat k, straight from the addressing rules.
  function automatic int beat_idx(input logic [31:0] a, input logic [1:0] bt, input int k);
    int s;
    s = int'((a >> 2) % DEPTH);
    if (bt == 2'b10) return (s / BL) * BL + ((s % BL) + k) % BL;
    return (s + k) % DEPTH;
  endfunction

  // One complete transaction; rst_cycle >= 1 asserts reset in that cycle after accept.
  task automatic xfer(input int sel, input logic [31:0] a, input logic [1:0] bt,
                      input logic wr, input bit hold, input int rst_cycle);
    int nb, w, cyc, idx;
    bit is_ack;
    logic [31:0] exp_rd, wv;
    logic [3:0]  sv;
    nb  = (bt == 2'b01 || bt == 2'b10) ? BL : 1;
    w   = (sel == 0) ? W0 : W1;
    cyc = 0;
    chk($sformatf("dut%0d stall_before_req", sel), {31'b0, stall[sel]}, 32'd0);
    req[sel]   = 1'b1;
    addr[sel]  = a;
    burst[sel] = bt;
    wrb[sel]   = wr;
    wdata[sel] = $urandom;
    strobe[sel] = 4'($urandom);
    rd_q.delete();
    for (int b = 0; b < nb; b++) begin
      for (int n = 1; n <= 1 + w; n++) begin
        step();
        cyc++;
        is_ack = (n == 1 + w);
        req[sel]   = hold;
        addr[sel]  = $urandom;
        burst[sel] = 2'($urandom);
        wrb[sel]   = 1'($urandom);
        if (wr && is_ack) begin
          wdata[sel]  = wd_q[b];
          strobe[sel] = st_q[b];
        end else begin
          wdata[sel]  = $urandom;
          strobe[sel] = 4'($urandom);
        end
        idx    = beat_idx(a, bt, b);
        exp_rd = (is_ack && !wr) ? mdl[sel][idx] : 32'h0;
        chk($sformatf("dut%0d ack c%0d", sel, cyc), {31'b0, ack[sel]}, {31'b0, is_ack});
        chk($sformatf("dut%0d stall c%0d", sel, cyc), {31'b0, stall[sel]}, 32'd1);
        chk($sformatf("dut%0d rdata c%0d", sel, cyc), rdata[sel], exp_rd);
        if (is_ack && !wr) rd_q.push_back(rdata[sel]);
        if (cyc == rst_cycle) begin
          rst = 1'b1;
          step();
          rst = 1'b0;
          req[sel] = 1'b0;
          chk($sformatf("dut%0d ack_after_rst", sel), {31'b0, ack[sel]}, 32'd0);
          chk($sformatf("dut%0d stall_after_rst", sel), {31'b0, stall[sel]}, 32'd0);
          chk($sformatf("dut%0d rdata_after_rst", sel), rdata[sel], 32'h0);
          return;
        end
        if (is_ack && wr) begin
          wv = wd_q[b];
          sv = st_q[b];
          for (int j = 0; j < 4; j++)
            if (sv[j]) mdl[sel][idx][8*j +: 8] = wv[8*j +: 8];
        end
      end
    end
    step();
    req[sel] = 1'b0;
    chk($sformatf("dut%0d ack_idle", sel), {31'b0, ack[sel]}, 32'd0);
    chk($sformatf("dut%0d stall_idle", sel), {31'b0, stall[sel]}, 32'd0);
    chk($sformatf("dut%0d rdata_idle", sel), rdata[sel], 32'h0);
  endtask

  task automatic chk_rd(input string tag, input int i, input logic [31:0] exp);
    logic [31:0] v;
    v = (i < rd_q.size()) ? rd_q[i] : 32'hxxxx_xxxx;
    chk(tag, v, exp);
  endtask

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      addr[s] = '0; burst[s] = '0; req[s] = 1'b0; wrb[s] = 1'b0;
      wdata[s] = '0; strobe[s] = '0;
    end
    repeat (3) step();
    req[0] = 1'b1;
    req[1] = 1'b1;
    step();
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("dut%0d reset_ack", s), {31'b0, ack[s]}, 32'd0);
      chk($sformatf("dut%0d reset_stall", s), {31'b0, stall[s]}, 32'd0);
      chk($sformatf("dut%0d reset_rdata", s), rdata[s], 32'h0);
    end
    req[0] = 1'b0;
    req[1] = 1'b0;
    rst = 1'b0;
    step();

    // Fill both memories so every model word is defined.
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < DEPTH / BL; k++) begin
        wd_q = '{$urandom, $urandom, $urandom, $urandom};
        st_q = '{4'hF, 4'hF, 4'hF, 4'hF};
        xfer(s, 32'(k * BL * 4), 2'b01, 1'b1, 1'b0, -1);
      end
    end

    wd_q = '{32'hDEADBEEF};
    st_q = '{4'hF};
    xfer(0, 32'h10, 2'b00, 1'b1, 1'b0, -1);
    xfer(0, 32'h10, 2'b00, 1'b0, 1'b0, -1);
    chk_rd("normal_readback", 0, 32'hDEADBEEF);

    wd_q = '{32'h1, 32'h2, 32'h3, 32'h4};
    st_q = '{4'hF, 4'hF, 4'hF, 4'hF};
    xfer(0, 32'h20, 2'b01, 1'b1, 1'b0, -1);
    xfer(0, 32'h20, 2'b01, 1'b0, 1'b1, -1);
    for (int i = 0; i < 4; i++) chk_rd($sformatf("incr_rd%0d", i), i, 32'(i + 1));

    xfer(0, 32'h28, 2'b10, 1'b0, 1'b0, -1);
    chk_rd("wrap_rd0", 0, 32'h3);
    chk_rd("wrap_rd1", 1, 32'h4);
    chk_rd("wrap_rd2", 2, 32'h1);
    chk_rd("wrap_rd3", 3, 32'h2);

    wd_q = '{32'h11223344};
    st_q = '{4'hF};
    xfer(0, 32'h30, 2'b00, 1'b1, 1'b0, -1);
    wd_q = '{32'h0000AB00};
    st_q = '{4'b0010};
    xfer(0, 32'h30, 2'b00, 1'b1, 1'b0, -1);
    xfer(0, 32'h30, 2'b00, 1'b0, 1'b0, -1);
    chk_rd("byte_write", 0, 32'h1122AB44);

    // Zero-wait burst with REQ held high, then the next request straight after.
    xfer(1, 32'h20, 2'b01, 1'b0, 1'b1, -1);
    xfer(1, 32'h10, 2'b00, 1'b0, 1'b0, -1);
    xfer(1, 32'hF8, 2'b01, 1'b0, 1'b0, -1);

    // Reset in the wait cycle after the second ACK of a write burst.
    wd_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    st_q = '{4'hF, 4'hF, 4'hF, 4'hF};
    xfer(0, 32'h40, 2'b01, 1'b1, 1'b0, -1);
    wd_q = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
    xfer(0, 32'h40, 2'b01, 1'b1, 1'b0, 5);
    xfer(0, 32'h40, 2'b01, 1'b0, 1'b0, -1);
    chk_rd("abort_rd0", 0, 32'hB0);
    chk_rd("abort_rd1", 1, 32'hB1);
    chk_rd("abort_rd2", 2, 32'hA2);
    chk_rd("abort_rd3", 3, 32'hA3);

    // Reset coinciding with the third ACK of a zero-wait write.
    wd_q = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
    xfer(1, 32'h40, 2'b01, 1'b1, 1'b0, -1);
    wd_q = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
    xfer(1, 32'h40, 2'b01, 1'b1, 1'b0, 3);
    xfer(1, 32'h40, 2'b01, 1'b0, 1'b0, -1);
    chk_rd("abort0w_rd1", 1, 32'hD1);
    chk_rd("abort0w_rd2", 2, 32'hC2);

    for (int t = 0; t < 60; t++) begin
      wd_q = '{$urandom, $urandom, $urandom, $urandom};
      st_q = '{4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom)};
      if (t % 10 == 0) st_q[0] = 4'b0000;
      xfer(t % 2, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
